// File: rtl/led_pattern_if.sv
// led_pattern_if: shift/flash LED pattern bus; master drives shift_leds, flash_leds, o_tick; slave (LED mux) reads them
interface led_pattern_if #(
  parameter int N_LEDS = 4
);
  logic [N_LEDS-1:0] shift_leds;
  logic [N_LEDS-1:0] flash_leds;
  logic              o_tick;
  modport master (output shift_leds, flash_leds, o_tick);
  modport slave  (input  shift_leds, flash_leds, o_tick);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled one-hot shift and blink LED pattern source; ports clock, i_reset_n (sync active-low), i_enable, i_speed_sel, i_dir, pat (master: shift_leds, flash_leds, o_tick); define LED_PINGPONG_EN for bouncing shift
module led_pattern_gen #(
  parameter int          N_LEDS = 4,
  parameter int          N_CNT  = 32,
  parameter int unsigned LIM0   = 2**23-1,
  parameter int unsigned LIM1   = 2**24-1,
  parameter int unsigned LIM2   = 2**25-1,
  parameter int unsigned LIM3   = 2**26-1
) (
  input  logic               clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic [1:0]         i_speed_sel,
  input  logic               i_dir,
  led_pattern_if.master      pat
);
  logic [N_CNT-1:0]  count, lim;
  logic [N_LEDS-1:0] rol, ror;
`ifdef LED_PINGPONG_EN
  typedef enum logic {UP, DOWN} state_t;
  state_t state;
  logic   bounce;
  always_comb bounce = (state == UP) ? pat.shift_leds[N_LEDS-1] : pat.shift_leds[0];
`endif
  always_comb begin
    lim = i_speed_sel == 2'd0 ? N_CNT'(LIM0) :
          i_speed_sel == 2'd1 ? N_CNT'(LIM1) :
          i_speed_sel == 2'd2 ? N_CNT'(LIM2) : N_CNT'(LIM3);
    rol = {pat.shift_leds[N_LEDS-2:0], pat.shift_leds[N_LEDS-1]};
    ror = {pat.shift_leds[0], pat.shift_leds[N_LEDS-1:1]};
  end
  always_ff @(posedge clock)
    if (!i_reset_n) begin
      count          <= '0;
      pat.shift_leds <= N_LEDS'(1);
      pat.flash_leds <= '0;
      pat.o_tick     <= 1'b0;
`ifdef LED_PINGPONG_EN
      state          <= UP;
`endif
    end else if (!i_enable) begin
      pat.o_tick     <= 1'b0;
    end else if (count >= lim) begin
      count          <= '0;
      pat.o_tick     <= 1'b1;
      pat.flash_leds <= ~pat.flash_leds;
`ifdef LED_PINGPONG_EN
      state          <= bounce ? ((state == UP) ? DOWN : UP) : state;
      pat.shift_leds <= ((state == UP) != bounce) ? rol : ror;
`else
      pat.shift_leds <= i_dir ? ror : rol;
`endif
    end else begin
      count          <= count + N_CNT'(1);
      pat.o_tick     <= 1'b0;
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed self-checking bench for led_pattern_gen with small prescaler limits
module tb_led_pattern_gen;
  logic       clock = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_enable = 1'b0;
  logic [1:0] i_speed_sel = 2'd0;
  logic       i_dir = 1'b0;
  logic [3:0] exp_s = 4'b0001;
  logic [3:0] exp_f = 4'b0000;
  int         checks = 0;
  int         failures = 0;
  led_pattern_if #(.N_LEDS(4)) pat();
  led_pattern_gen #(
    .N_LEDS(4), .N_CNT(32), .LIM0(3), .LIM1(7), .LIM2(15), .LIM3(31)
  ) dut (
    .clock(clock), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_speed_sel(i_speed_sel), .i_dir(i_dir), .pat(pat)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
`ifdef LED_PINGPONG_EN
    i_dir = 1'($urandom_range(0, 1));
`endif
  endtask
  task automatic chk(input string tag, input logic et);
    checks += 3;
    assert (pat.shift_leds === exp_s) else begin
      failures++;
      $error("FAIL %s shift_leds got=%b exp=%b", tag, pat.shift_leds, exp_s);
    end
    assert (pat.flash_leds === exp_f) else begin
      failures++;
      $error("FAIL %s flash_leds got=%b exp=%b", tag, pat.flash_leds, exp_f);
    end
    assert (pat.o_tick === et) else begin
      failures++;
      $error("FAIL %s o_tick got=%b exp=%b", tag, pat.o_tick, et);
    end
  endtask
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, 1'b0);
    end
  endtask
  task automatic period(input int n, input logic [3:0] ns, input logic [3:0] nf, input string tag);
    idle(n - 1, tag);
    step();
    exp_s = ns;
    exp_f = nf;
    chk(tag, 1'b1);
  endtask
  initial begin
    step();
    step();
    chk("reset", 1'b0);
    i_reset_n = 1'b1;
    i_enable  = 1'b1;
`ifdef LED_PINGPONG_EN
    period(4, 4'b0010, 4'b1111, "pp1");
    period(4, 4'b0100, 4'b0000, "pp2");
    period(4, 4'b1000, 4'b1111, "pp3");
    period(4, 4'b0100, 4'b0000, "pp4");
    period(4, 4'b0010, 4'b1111, "pp5");
    period(4, 4'b0001, 4'b0000, "pp6");
    period(4, 4'b0010, 4'b1111, "pp7");
    period(4, 4'b0100, 4'b0000, "pp8");
`else
    period(4, 4'b0010, 4'b1111, "s0_a");
    period(4, 4'b0100, 4'b0000, "s0_b");
    period(4, 4'b1000, 4'b1111, "s0_c");
    period(4, 4'b0001, 4'b0000, "s0_wrap");
    i_dir       = 1'b1;
    i_speed_sel = 2'd1;
    period(8, 4'b1000, 4'b1111, "s1_right_a");
    period(8, 4'b0100, 4'b0000, "s1_right_b");
    i_dir       = 1'b0;
    i_speed_sel = 2'd3;
    idle(20, "s3_count");
    i_speed_sel = 2'd0;
    step();
    exp_s = 4'b1000;
    exp_f = 4'b1111;
    chk("speed_drop", 1'b1);
    period(4, 4'b0001, 4'b0000, "after_drop");
    idle(2, "pre_hold");
    i_enable = 1'b0;
    idle(10, "hold");
    i_enable = 1'b1;
    period(2, 4'b0010, 4'b1111, "resume");
    i_enable = 1'b0;
    idle(1, "en_low_at_tick");
    i_enable = 1'b1;
    period(4, 4'b0100, 4'b0000, "after_tick_hold");
    period(4, 4'b1000, 4'b1111, "pre_reset");
    idle(2, "mid_period");
    i_reset_n = 1'b0;
    step();
    exp_s = 4'b0001;
    exp_f = 4'b0000;
    chk("mid_reset", 1'b0);
    i_reset_n = 1'b1;
    period(4, 4'b0010, 4'b1111, "post_reset");
    i_speed_sel = 2'd2;
    period(16, 4'b0100, 4'b0000, "s2");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
